fire_zone_scan_ctrl: RTL and testbench

Scan controller for a multi-zone fire alarm board. Round-robin it polls NUM_ZONES temperature sensors through one shared sample handshake. Per zone it debounces over-threshold readings, latches the zone alarm and flags sensors that stop responding. It drives the board alarm and display outputs, and sits between the sensor interface and the panel.

---
 rtl/fire_pkg.sv | 24 ++
 rtl/fire_zone_tracker.sv | 73 +++++++
 rtl/fire_zone_scan_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_fire_zone_scan_ctrl.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fire_pkg.sv
// Shared definitions for the fire alarm board: temperature type, scan FSM
// state encoding and the board-wide default alarm constants.
package fire_pkg;

  // Unsigned temperature in 0.1 degC units.
  typedef logic [15:0] temp_t;

  // Scan controller states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_EVAL = 2'd2
  } scan_state_t;

  // Board defaults, also used by the mainboard firmware.
  localparam int DEF_THRESHOLD   = 500;   // 50.0 degC
  localparam int DEF_HYSTERESIS  = 20;    // 2.0 degC clear band
  localparam int DEF_SCAN_PERIOD = 1000;  // cycles between scan starts

  function automatic temp_t max_temp(input temp_t a, input temp_t b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/fire_zone_tracker.sv
// Per-zone alarm state: consecutive-hot counter, latched alarm, pending
// operator acknowledge and the most recent valid reading.
module fire_zone_tracker
  import fire_pkg::*;
#(
  parameter int THRESHOLD       = DEF_THRESHOLD,
  parameter int HYSTERESIS      = DEF_HYSTERESIS,
  parameter int CONFIRM_SAMPLES = 3
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  eval_en,    // this zone is in its EVAL cycle
  input  logic  sample_ok,  // a reading was captured (not a timeout)
  input  temp_t sample,
  input  logic  ack,
  output logic  alarm_zone,
  output temp_t last_temp
);

  localparam int CW = $clog2(CONFIRM_SAMPLES + 1);
  localparam temp_t HOT_LEVEL  = temp_t'(THRESHOLD);
  localparam temp_t COOL_LEVEL = temp_t'(THRESHOLD - HYSTERESIS);
  localparam logic [CW-1:0] CNT_MAX = CW'(CONFIRM_SAMPLES);

  logic [CW-1:0] hot_cnt;
  logic [CW-1:0] cnt_next;
  logic          ack_pending;
  logic          pend_next;
  logic          hot;
  logic          cool;
  logic          confirm;

  // Next counter value for the current reading; ack is folded in before the
  // EVAL decision so a same-cycle ack already counts.
  always_comb begin
    hot      = (sample >= HOT_LEVEL);
    cool     = (sample < COOL_LEVEL);
    cnt_next = hot_cnt;
    if (hot) begin
      if (hot_cnt != CNT_MAX) cnt_next = hot_cnt + 1'b1;
    end else if (cool) begin
      cnt_next = '0;
    end
    // Only a hot reading confirms; a saturated counter held by an in-band
    // reading must not cancel a pending acknowledge.
    confirm   = hot && (cnt_next == CNT_MAX);
    pend_next = ack_pending | (ack & alarm_zone);
  end

  // Zone state update: ack arms the cool-down clear, EVAL applies the reading.
  always_ff @(posedge clk) begin
    if (reset) begin
      hot_cnt     <= '0;
      alarm_zone  <= 1'b0;
      ack_pending <= 1'b0;
      last_temp   <= '0;
    end else begin
      ack_pending <= pend_next;
      if (eval_en && sample_ok) begin
        last_temp <= sample;
        hot_cnt   <= cnt_next;
        if (confirm) begin
          alarm_zone  <= 1'b1;
          ack_pending <= 1'b0;
        end else if (cool && pend_next) begin
          alarm_zone  <= 1'b0;
          ack_pending <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/fire_zone_scan_ctrl.sv
// Round-robin scan controller for the multi-zone fire alarm board.
// Polls each zone through one sample_req/sample_valid handshake, feeds the
// per-zone trackers and drives the board alarm and panel display.
//
// Handshake: sample_req is high for exactly the WAIT state of a zone and
// sample_zone is stable while it is high; a reading is taken on the first
// clock edge where sample_req=1 and sample_valid=1, after which sample_req
// drops on the next cycle. sample_valid without sample_req is ignored.
//
// Build option FIRE_SILENCE_TIMER_EN: ack also silences the board alarm for
// SILENCE_CYCLES cycles unless a new zone latches during the window.
module fire_zone_scan_ctrl
  import fire_pkg::*;
#(
  parameter int NUM_ZONES       = 4,
  parameter int THRESHOLD       = DEF_THRESHOLD,
  parameter int HYSTERESIS      = DEF_HYSTERESIS,
  parameter int CONFIRM_SAMPLES = 3,
  parameter int SCAN_PERIOD     = DEF_SCAN_PERIOD,
  parameter int TIMEOUT_CYCLES  = 64,
  parameter int SILENCE_CYCLES  = 50000,
  localparam int ZW = $clog2(NUM_ZONES)
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic                 sample_req,
  output logic [ZW-1:0]        sample_zone,
  input  logic                 sample_valid,
  input  logic [15:0]          sample_data,
  input  logic                 ack,
  output logic                 alarm,
  output logic [NUM_ZONES-1:0] alarm_zone,
  output logic [NUM_ZONES-1:0] fault_zone,
  output logic [15:0]          display
);

  localparam int TW = $clog2(SCAN_PERIOD + 1);
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMER_RELOAD = TW'(SCAN_PERIOD - 1);
  localparam logic [WW-1:0] WAIT_LAST    = WW'(TIMEOUT_CYCLES - 1);
  localparam logic [ZW-1:0] ZONE_LAST    = ZW'(NUM_ZONES - 1);

  // The clear band must sit at or above zero; the silence window must exist.
  if (THRESHOLD < HYSTERESIS || SILENCE_CYCLES < 1) begin : g_param_check
    $error("fire_zone_scan_ctrl: illegal THRESHOLD/HYSTERESIS/SILENCE_CYCLES");
  end

  scan_state_t   state;
  logic [TW-1:0] scan_timer;
  logic [WW-1:0] wait_cnt;
  logic [ZW-1:0] zone;
  temp_t         sample_q;
  logic          sample_ok;
  logic          eval_done;
  temp_t         last_temp [NUM_ZONES];
  temp_t         disp_next;
  logic          alarm_next;

  assign sample_req  = (state == ST_WAIT);
  assign sample_zone = zone;

  // Scan sequencer: period timer, zone walk, capture and timeout handling.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      scan_timer <= '0;
      wait_cnt   <= '0;
      zone       <= '0;
      sample_q   <= '0;
      sample_ok  <= 1'b0;
      fault_zone <= '0;
      eval_done  <= 1'b0;
    end else begin
      eval_done <= (state == ST_EVAL);
      // The period timer runs through the scan; an overrun parks it at zero.
      if (scan_timer != '0) scan_timer <= scan_timer - 1'b1;
      case (state)
        ST_IDLE: begin
          if (scan_timer == '0) begin
            scan_timer <= TIMER_RELOAD;
            zone       <= '0;
            wait_cnt   <= '0;
            state      <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (sample_valid) begin
            sample_q  <= sample_data;
            sample_ok <= 1'b1;
            state     <= ST_EVAL;
          end else if (wait_cnt == WAIT_LAST) begin
            fault_zone[zone] <= 1'b1;
            sample_ok        <= 1'b0;
            state            <= ST_EVAL;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_EVAL: begin
          if (sample_ok) fault_zone[zone] <= 1'b0;
          if (zone == ZONE_LAST) begin
            state <= ST_IDLE;
          end else begin
            zone     <= zone + 1'b1;
            wait_cnt <= '0;
            state    <= ST_WAIT;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < NUM_ZONES; i++) begin : g_zone
    fire_zone_tracker #(
      .THRESHOLD      (THRESHOLD),
      .HYSTERESIS     (HYSTERESIS),
      .CONFIRM_SAMPLES(CONFIRM_SAMPLES)
    ) u_tracker (
      .clk       (clk),
      .reset     (reset),
      .eval_en   ((state == ST_EVAL) && (zone == ZW'(i))),
      .sample_ok (sample_ok),
      .sample    (sample_q),
      .ack       (ack),
      .alarm_zone(alarm_zone[i]),
      .last_temp (last_temp[i])
    );
  end

  // Panel value: lowest-index alarmed zone wins, else the hottest zone.
  always_comb begin
    temp_t pick;
    temp_t hottest;
    logic  any;
    pick    = '0;
    hottest = '0;
    any     = 1'b0;
    for (int i = NUM_ZONES - 1; i >= 0; i--) begin
      if (alarm_zone[i]) begin
        pick = last_temp[i];
        any  = 1'b1;
      end
      hottest = max_temp(hottest, last_temp[i]);
    end
    disp_next = any ? pick : hottest;
  end

`ifdef FIRE_SILENCE_TIMER_EN
  localparam int SW = $clog2(SILENCE_CYCLES + 1);
  logic [SW-1:0]        silence_cnt;
  logic [NUM_ZONES-1:0] alarm_zone_q;
  logic                 new_latch;

  assign new_latch  = |(alarm_zone & ~alarm_zone_q);
  assign alarm_next = (|alarm_zone) && (new_latch || (!ack && silence_cnt == '0));

  // Silence window: loaded by ack, cut short by any newly latched zone.
  always_ff @(posedge clk) begin
    if (reset) begin
      silence_cnt  <= '0;
      alarm_zone_q <= '0;
    end else begin
      alarm_zone_q <= alarm_zone;
      if (new_latch)               silence_cnt <= '0;
      else if (ack)                silence_cnt <= SW'(SILENCE_CYCLES);
      else if (silence_cnt != '0)  silence_cnt <= silence_cnt - 1'b1;
    end
  end
`else
  assign alarm_next = |alarm_zone;
`endif

  // Board outputs: alarm follows the zone latches one cycle later, display
  // refreshes the cycle after every EVAL.
  always_ff @(posedge clk) begin
    if (reset) begin
      alarm   <= 1'b0;
      display <= '0;
    end else begin
      alarm <= alarm_next;
      if (eval_done) display <= disp_next;
    end
  end

endmodule

// File: tb/tb_fire_zone_scan_ctrl.sv
// Directed bench for fire_zone_scan_ctrl with a behavioural sensor model.
module tb_fire_zone_scan_ctrl;

  localparam int NZ = 4;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          sample_req;
  logic [1:0]    sample_zone;
  logic          sample_valid = 1'b0;
  logic [15:0]   sample_data = '0;
  logic          ack = 1'b0;
  logic          alarm;
  logic [NZ-1:0] alarm_zone;
  logic [NZ-1:0] fault_zone;
  logic [15:0]   display;

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  fire_zone_scan_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .sample_req  (sample_req),
    .sample_zone (sample_zone),
    .sample_valid(sample_valid),
    .sample_data (sample_data),
    .ack         (ack),
    .alarm       (alarm),
    .alarm_zone  (alarm_zone),
    .fault_zone  (fault_zone),
    .display     (display)
  );

  // ---------------- sensor model ----------------
  logic [15:0]   zone_temp [NZ];
  logic [NZ-1:0] mute = '0;
  logic          junk = 1'b0;

  always @(negedge clk) begin
    if (sample_req && !mute[sample_zone]) begin
      sample_valid = 1'b1;
      sample_data  = zone_temp[sample_zone];
    end else if (junk && !sample_req) begin
      sample_valid = 1'b1;
      sample_data  = 16'd900;
    end else begin
      sample_valid = 1'b0;
      sample_data  = '0;
    end
  end

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];
  int req_len [NZ];
  int scan_start = 0;
  int prev_start = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_all(input logic [15:0] t);
    for (int i = 0; i < NZ; i++) zone_temp[i] = t;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic pulse_ack();
    @(negedge clk) ack = 1'b1;
    @(negedge clk) ack = 1'b0;
  endtask

  task automatic wait_req_zone(input int z, input int budget);
    int g;
    g = 0;
    while (!(sample_req && sample_zone == 2'(z)) && g < budget) begin
      @(negedge clk);
      g++;
    end
    check("req_wait", 32'(g < budget), 1);
  endtask

  // Returns at the EVAL cycle of zone z.
  task automatic wait_capture(input int z);
    int g;
    wait_req_zone(z, 2500);
    g = 0;
    while (sample_req && g < 200) begin
      @(negedge clk);
      g++;
    end
    check("capture_wait", 32'(g < 200), 1);
  endtask

  // One full scan; returns once display/alarm reflect the last zone.
  task automatic run_scan();
    int g;
    wait_req_zone(0, 2500);
    prev_start = scan_start;
    scan_start = cyc;
    for (int k = 0; k < NZ; k++) exp_q.push_back(32'(k));
    for (int k = 0; k < NZ; k++) begin
      g = 0;
      while (!sample_req && g < 200) begin
        @(negedge clk);
        g++;
      end
      check("scan_zone", 32'(sample_zone), exp_q.pop_front());
      g = 0;
      while (sample_req && g < 200) begin
        @(negedge clk);
        g++;
      end
      req_len[k] = g;
    end
    repeat (2) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #1200000;
    $display("FAIL watchdog: simulation did not finish (total=%0d bad=%0d)", total, bad);
    $fatal(1);
  end

  initial begin
    set_all(16'd300);

    // Reset values while reset is held.
    repeat (3) @(negedge clk);
    check("rst_req", 32'(sample_req), 0);
    check("rst_zone", 32'(sample_zone), 0);
    check("rst_alarm", 32'(alarm), 0);
    check("rst_alarm_zone", 32'(alarm_zone), 0);
    check("rst_fault", 32'(fault_zone), 0);
    check("rst_display", 32'(display), 0);
    reset = 1'b0;

    // Responsive sensors at 30.0 degC; junk valids outside WAIT are ignored.
    run_scan();
    check("cool_display", 32'(display), 300);
    check("cool_alarm", 32'(alarm), 0);
    check("cool_fault", 32'(fault_zone), 0);
    check("cool_req_len", 32'(req_len[2]), 1);
    junk = 1'b1;
    run_scan();
    junk = 1'b0;
    check("scan_period", 32'(scan_start - prev_start), 1000);
    check("junk_display", 32'(display), 300);
    check("junk_alarm_zone", 32'(alarm_zone), 0);

    // Zone 2 hot: latches on the third scan.
    do_reset();
    zone_temp[2] = 16'd600;
    for (int s = 0; s < 2; s++) begin
      run_scan();
      check("hot_pre_alarm_zone", 32'(alarm_zone), 0);
      check("hot_pre_display", 32'(display), 600);
    end
    wait_capture(2);
    check("hot_eval_alarm_zone", 32'(alarm_zone), 0);
    @(negedge clk);
    check("hot_latch_alarm_zone", 32'(alarm_zone), 4'b0100);
    check("hot_latch_alarm", 32'(alarm), 0);
    @(negedge clk);
    check("hot_alarm", 32'(alarm), 1);
    check("hot_display", 32'(display), 600);
    wait_capture(NZ - 1);
    repeat (2) @(negedge clk);

    // Cooling without ack keeps the latch.
    zone_temp[2] = 16'd470;
    run_scan();
    check("noack_alarm_zone", 32'(alarm_zone), 4'b0100);
    check("noack_display", 32'(display), 470);
    // Ack, then in-band reading: held. Then below band: cleared.
    pulse_ack();
    zone_temp[2] = 16'd490;
    run_scan();
    check("band_alarm_zone", 32'(alarm_zone), 4'b0100);
    check("band_alarm", 32'(alarm), 1);
    check("band_display", 32'(display), 490);
    zone_temp[2] = 16'd470;
    run_scan();
    check("clear_alarm_zone", 32'(alarm_zone), 0);
    check("clear_alarm", 32'(alarm), 0);
    check("clear_display", 32'(display), 470);

    // Re-confirm after ack cancels the pending clear.
    zone_temp[2] = 16'd600;
    repeat (3) run_scan();
    check("relatch_alarm_zone", 32'(alarm_zone), 4'b0100);
    pulse_ack();
    run_scan();
    zone_temp[2] = 16'd470;
    run_scan();
    check("reconfirm_alarm_zone", 32'(alarm_zone), 4'b0100);
    pulse_ack();
    run_scan();
    check("reack_alarm_zone", 32'(alarm_zone), 0);

    // Zone 1 alternating hot/cool never confirms.
    do_reset();
    set_all(16'd300);
    for (int s = 0; s < 6; s++) begin
      zone_temp[1] = (s % 2 == 0) ? 16'd600 : 16'd300;
      run_scan();
      check("alt_alarm_zone", 32'(alarm_zone), 0);
      check("alt_display", 32'(display), (s % 2 == 0) ? 600 : 300);
    end
    check("alt_alarm", 32'(alarm), 0);

    // Silent zone 3: 64-cycle request, fault flag, then cleared by a reading.
    do_reset();
    set_all(16'd300);
    mute[3] = 1'b1;
    run_scan();
    check("to_req_len3", 32'(req_len[3]), 64);
    check("to_req_len0", 32'(req_len[0]), 1);
    check("to_fault", 32'(fault_zone), 4'b1000);
    check("to_display", 32'(display), 300);
    mute[3] = 1'b0;
    run_scan();
    check("to_period", 32'(scan_start - prev_start), 1000);
    check("to_fault_clear", 32'(fault_zone), 0);

    // Reset during WAIT of zone 1 aborts everything.
    do_reset();
    set_all(16'd300);
    zone_temp[0] = 16'd600;
    repeat (3) run_scan();
    check("pre_rst_alarm_zone", 32'(alarm_zone), 4'b0001);
    check("pre_rst_display", 32'(display), 600);
    mute[1] = 1'b1;
    wait_req_zone(1, 2500);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_req", 32'(sample_req), 0);
    check("mid_rst_zone", 32'(sample_zone), 0);
    check("mid_rst_alarm_zone", 32'(alarm_zone), 0);
    check("mid_rst_alarm", 32'(alarm), 0);
    check("mid_rst_display", 32'(display), 0);
    repeat (2) @(negedge clk);
    mute[1] = 1'b0;
    set_all(16'd300);
    reset = 1'b0;
    run_scan();
    check("post_rst_display", 32'(display), 300);
    check("post_rst_alarm", 32'(alarm), 0);
    check("post_rst_fault", 32'(fault_zone), 0);

    // ---------------- report ----------------
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
